// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared pipeline constants: operand-source selects, ALU
//               operation encodings and default datapath widths.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_REG_AW = 5;

    // Operand-source selects that mean "this operand comes from the register file"
    localparam logic [1:0] ALUSRCA_RS = 2'b01;
    localparam logic [2:0] ALUSRCB_RT = 3'b000;

    typedef enum logic [3:0] {
        ALUOP_ADD = 4'd0,
        ALUOP_SUB = 4'd1,
        ALUOP_AND = 4'd2,
        ALUOP_OR  = 4'd3,
        ALUOP_XOR = 4'd4,
        ALUOP_NOR = 4'd5,
        ALUOP_SLT = 4'd6,
        ALUOP_SLL = 4'd7,
        ALUOP_SRL = 4'd8,
        ALUOP_SRA = 4'd9,
        ALUOP_LUI = 4'd10
    } aluop_e;

endpackage
`default_nettype wire

// File: rtl/load_use_detect.sv
`default_nettype none
// ============================================================================
// Module      : load_use_detect
// Description : Combinational load-use hazard detector for the ID/EX boundary.
// Revision    : 1.0 - initial release
// ============================================================================
module load_use_detect
    import mips_pkg::*;
#(
    parameter int REG_AW = DEF_REG_AW
) (
    input  logic              ID_EX_MemRead,
    input  logic [REG_AW-1:0] ID_EX_Rt,
    input  logic [REG_AW-1:0] IF_ID_Rs,
    input  logic [REG_AW-1:0] IF_ID_Rt,
    input  logic [1:0]        ID_ALUSrcA,
    input  logic [2:0]        ID_ALUSrcB,
    input  logic              ID_MemWrite,
    output logic              hazard
);

    logic w_uses_rs;
    logic w_uses_rt;
    logic w_rs_match;
    logic w_rt_match;

    // A store reads rt as its data operand even when ALUSrcB selects the immediate
    assign w_uses_rs  = (ID_ALUSrcA == ALUSRCA_RS);
    assign w_uses_rt  = (ID_ALUSrcB == ALUSRCB_RT) || ID_MemWrite;
    assign w_rs_match = w_uses_rs && (ID_EX_Rt == IF_ID_Rs);
    assign w_rt_match = w_uses_rt && (ID_EX_Rt == IF_ID_Rt);

    assign hazard = ID_EX_MemRead && (ID_EX_Rt != '0) && (w_rs_match || w_rt_match);

endmodule
`default_nettype wire

// File: rtl/id_ex_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage_reg
// Description : ID/EX pipeline register with load-use stall, bubble insertion
//               on stall or flush, and a saturating bubble counter.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage_reg
    import mips_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_AW = DEF_REG_AW,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [REG_AW-1:0] IF_ID_Rs,
    input  logic [REG_AW-1:0] IF_ID_Rt,
    input  logic [REG_AW-1:0] IF_ID_Rd,
    input  logic              ID_RegWrite,
    input  logic              ID_MemRead,
    input  logic              ID_MemWrite,
    input  logic              ID_MemtoReg,
    input  logic [1:0]        ID_RegDst,
    input  logic [1:0]        ID_ALUSrcA,
    input  logic [2:0]        ID_ALUSrcB,
    input  logic [3:0]        ID_ALUOp,
    input  logic [DATA_W-1:0] ID_ReadData1,
    input  logic [DATA_W-1:0] ID_ReadData2,
    input  logic [DATA_W-1:0] ID_Imm,
    input  logic [DATA_W-1:0] ID_PC4,
    output logic [REG_AW-1:0] ID_EX_Rs,
    output logic [REG_AW-1:0] ID_EX_Rt,
    output logic [REG_AW-1:0] ID_EX_Rd,
    output logic              ID_EX_RegWrite,
    output logic              ID_EX_MemRead,
    output logic              ID_EX_MemWrite,
    output logic              ID_EX_MemtoReg,
    output logic [1:0]        ID_EX_RegDst,
    output logic [1:0]        ID_EX_ALUSrcA,
    output logic [2:0]        ID_EX_ALUSrcB,
    output logic [3:0]        ID_EX_ALUOp,
    output logic [DATA_W-1:0] ID_EX_ReadData1,
    output logic [DATA_W-1:0] ID_EX_ReadData2,
    output logic [DATA_W-1:0] ID_EX_Imm,
    output logic [DATA_W-1:0] ID_EX_PC4,
    output logic              PCWrite,
    output logic              IF_ID_Write,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    logic w_hazard;
    logic w_bubble;

    load_use_detect #(
        .REG_AW (REG_AW)
    ) u_load_use_detect (
        .ID_EX_MemRead (ID_EX_MemRead),
        .ID_EX_Rt      (ID_EX_Rt),
        .IF_ID_Rs      (IF_ID_Rs),
        .IF_ID_Rt      (IF_ID_Rt),
        .ID_ALUSrcA    (ID_ALUSrcA),
        .ID_ALUSrcB    (ID_ALUSrcB),
        .ID_MemWrite   (ID_MemWrite),
        .hazard        (w_hazard)
    );

    // Flush does not gate the stall: the PC source mux already overrides on a taken branch
    assign PCWrite     = !w_hazard;
    assign IF_ID_Write = !w_hazard;
    assign w_bubble    = flush || w_hazard;

    // An all-zero register is the bubble, so reset and bubble share one clear path
    always_ff @(posedge clk) begin
        if (rst || w_bubble) begin
            ID_EX_Rs        <= '0;
            ID_EX_Rt        <= '0;
            ID_EX_Rd        <= '0;
            ID_EX_RegWrite  <= 1'b0;
            ID_EX_MemRead   <= 1'b0;
            ID_EX_MemWrite  <= 1'b0;
            ID_EX_MemtoReg  <= 1'b0;
            ID_EX_RegDst    <= '0;
            ID_EX_ALUSrcA   <= '0;
            ID_EX_ALUSrcB   <= '0;
            ID_EX_ALUOp     <= '0;
            ID_EX_ReadData1 <= '0;
            ID_EX_ReadData2 <= '0;
            ID_EX_Imm       <= '0;
            ID_EX_PC4       <= '0;
        end else begin
            ID_EX_Rs        <= IF_ID_Rs;
            ID_EX_Rt        <= IF_ID_Rt;
            ID_EX_Rd        <= IF_ID_Rd;
            ID_EX_RegWrite  <= ID_RegWrite;
            ID_EX_MemRead   <= ID_MemRead;
            ID_EX_MemWrite  <= ID_MemWrite;
            ID_EX_MemtoReg  <= ID_MemtoReg;
            ID_EX_RegDst    <= ID_RegDst;
            ID_EX_ALUSrcA   <= ID_ALUSrcA;
            ID_EX_ALUSrcB   <= ID_ALUSrcB;
            ID_EX_ALUOp     <= ID_ALUOp;
            ID_EX_ReadData1 <= ID_ReadData1;
            ID_EX_ReadData2 <= ID_ReadData2;
            ID_EX_Imm       <= ID_Imm;
            ID_EX_PC4       <= ID_PC4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt <= '0;
        end else if (w_bubble && (bubble_cnt != '1)) begin
            bubble_cnt <= bubble_cnt + c_cnt_one;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_stage_reg
// Description : Self-checking bench for id_ex_stage_reg (scoreboard of
//               expected ID/EX contents per clock edge).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage_reg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 16;

    typedef struct packed {
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic              memread;
        logic              memwrite;
        logic              memtoreg;
        logic [1:0]        regdst;
        logic [1:0]        alusrca;
        logic [2:0]        alusrcb;
        logic [3:0]        aluop;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] pc4;
    } ex_t;

    localparam ex_t c_bubble = '0;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    ex_t  id;
    ex_t  got;
    ex_t  e;

    logic [REG_AW-1:0] ex_rs, ex_rt, ex_rd;
    logic              ex_rw, ex_mr, ex_mw, ex_m2r;
    logic [1:0]        ex_rdst, ex_asa;
    logic [2:0]        ex_asb;
    logic [3:0]        ex_op;
    logic [DATA_W-1:0] ex_rd1, ex_rd2, ex_imm, ex_pc4;
    logic              pc_write, if_id_write;
    logic [CNT_W-1:0]  bubble_cnt;

    int total  = 0;
    int passed = 0;
    ex_t exp_q[$];
    logic [CNT_W-1:0] exp_cnt;

    always #5 clk = ~clk;

    id_ex_stage_reg #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW),
        .CNT_W  (CNT_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .IF_ID_Rs        (id.rs),
        .IF_ID_Rt        (id.rt),
        .IF_ID_Rd        (id.rd),
        .ID_RegWrite     (id.regwrite),
        .ID_MemRead      (id.memread),
        .ID_MemWrite     (id.memwrite),
        .ID_MemtoReg     (id.memtoreg),
        .ID_RegDst       (id.regdst),
        .ID_ALUSrcA      (id.alusrca),
        .ID_ALUSrcB      (id.alusrcb),
        .ID_ALUOp        (id.aluop),
        .ID_ReadData1    (id.rd1),
        .ID_ReadData2    (id.rd2),
        .ID_Imm          (id.imm),
        .ID_PC4          (id.pc4),
        .ID_EX_Rs        (ex_rs),
        .ID_EX_Rt        (ex_rt),
        .ID_EX_Rd        (ex_rd),
        .ID_EX_RegWrite  (ex_rw),
        .ID_EX_MemRead   (ex_mr),
        .ID_EX_MemWrite  (ex_mw),
        .ID_EX_MemtoReg  (ex_m2r),
        .ID_EX_RegDst    (ex_rdst),
        .ID_EX_ALUSrcA   (ex_asa),
        .ID_EX_ALUSrcB   (ex_asb),
        .ID_EX_ALUOp     (ex_op),
        .ID_EX_ReadData1 (ex_rd1),
        .ID_EX_ReadData2 (ex_rd2),
        .ID_EX_Imm       (ex_imm),
        .ID_EX_PC4       (ex_pc4),
        .PCWrite         (pc_write),
        .IF_ID_Write     (if_id_write),
        .bubble_cnt      (bubble_cnt)
    );

    assign got = {ex_rs, ex_rt, ex_rd, ex_rw, ex_mr, ex_mw, ex_m2r, ex_rdst,
                  ex_asa, ex_asb, ex_op, ex_rd1, ex_rd2, ex_imm, ex_pc4};

    function automatic ex_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                               input logic rw, input logic mr, input logic mw, input logic m2r,
                               input logic [1:0] rdst, input logic [1:0] asa,
                               input logic [2:0] asb, input logic [3:0] op);
        ex_t t;
        t.rs = rs; t.rt = rt; t.rd = rd;
        t.regwrite = rw; t.memread = mr; t.memwrite = mw; t.memtoreg = m2r;
        t.regdst = rdst; t.alusrca = asa; t.alusrcb = asb; t.aluop = op;
        t.rd1 = $urandom; t.rd2 = $urandom; t.imm = $urandom; t.pc4 = $urandom;
        return t;
    endfunction

    function automatic ex_t add_i(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        return mk(rs, rt, rd, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 3'b000, 4'd0);
    endfunction

    function automatic ex_t lw_i(input logic [4:0] rt, input logic [4:0] base);
        return mk(base, rt, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 2'b01, 3'b001, 4'd0);
    endfunction

    function automatic ex_t sw_i(input logic [4:0] rt, input logic [4:0] base);
        return mk(base, rt, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b01, 3'b001, 4'd0);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bump_cnt();
        if (exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; id = add_i(5'd9, 5'd8, 5'd7);
        tick(); tick();
        rst = 1'b0;
        exp_cnt = '0;
        total++;
        if (got !== c_bubble) $display("FAIL reset_regs: got %h expected %h", got, c_bubble);
        else passed++;
        total++;
        if (bubble_cnt !== exp_cnt) $display("FAIL reset_cnt: got %h expected %h", bubble_cnt, exp_cnt);
        else passed++;
        total++;
        if ({pc_write, if_id_write} !== 2'b11)
            $display("FAIL reset_pcwrite: got %b expected 11", {pc_write, if_id_write});
        else passed++;
    endtask

    task automatic test_no_dep();
        id = add_i(5'd3, 5'd1, 5'd2);
        #1;
        total++;
        if (pc_write !== 1'b1) $display("FAIL nodep_pcwrite: got %b expected 1", pc_write);
        else passed++;
        exp_q.push_back(id);
        tick();
        e = exp_q.pop_front();
        total++;
        if (got !== e) $display("FAIL nodep_capture: got %h expected %h", got, e);
        else passed++;
        total++;
        if (bubble_cnt !== exp_cnt) $display("FAIL nodep_cnt: got %h expected %h", bubble_cnt, exp_cnt);
        else passed++;
    endtask

    // Load in EX, dependent instruction in ID: one bubble, then the held instruction
    task automatic test_load_use(input string name, input ex_t ld, input ex_t user);
        id = ld;
        exp_q.push_back(ld);
        tick();
        e = exp_q.pop_front();
        total++;
        if (got !== e) $display("FAIL %s_load: got %h expected %h", name, got, e);
        else passed++;
        id = user;
        #1;
        total++;
        if ({pc_write, if_id_write} !== 2'b00)
            $display("FAIL %s_stall: got %b expected 00", name, {pc_write, if_id_write});
        else passed++;
        exp_q.push_back(c_bubble);
        bump_cnt();
        tick();
        e = exp_q.pop_front();
        total++;
        if (got !== e) $display("FAIL %s_bubble: got %h expected %h", name, got, e);
        else passed++;
        total++;
        if (bubble_cnt !== exp_cnt) $display("FAIL %s_cnt: got %h expected %h", name, bubble_cnt, exp_cnt);
        else passed++;
        total++;
        if ({pc_write, if_id_write} !== 2'b11)
            $display("FAIL %s_release: got %b expected 11", name, {pc_write, if_id_write});
        else passed++;
        exp_q.push_back(user);
        tick();
        e = exp_q.pop_front();
        total++;
        if (got !== e) $display("FAIL %s_capture: got %h expected %h", name, got, e);
        else passed++;
    endtask

    task automatic test_back_to_back();
        test_load_use("b2b_first", lw_i(5'd5, 5'd1), lw_i(5'd6, 5'd5));
        // EX now holds lw r6; the add depends on it and must get its own single bubble
        id = add_i(5'd7, 5'd6, 5'd6);
        #1;
        total++;
        if (pc_write !== 1'b0) $display("FAIL b2b_second_stall: got %b expected 0", pc_write);
        else passed++;
        exp_q.push_back(c_bubble);
        bump_cnt();
        tick();
        exp_q.push_back(id);
        tick();
        e = exp_q.pop_front();
        e = exp_q.pop_front();
        total++;
        if (got !== e) $display("FAIL b2b_second_capture: got %h expected %h", got, e);
        else passed++;
        total++;
        if (bubble_cnt !== exp_cnt) $display("FAIL b2b_cnt: got %h expected %h", bubble_cnt, exp_cnt);
        else passed++;
    endtask

    task automatic test_load_r0();
        id = lw_i(5'd0, 5'd3);
        exp_q.push_back(id);
        tick();
        e = exp_q.pop_front();
        id = add_i(5'd1, 5'd0, 5'd0);
        #1;
        total++;
        if (pc_write !== 1'b1) $display("FAIL r0_pcwrite: got %b expected 1", pc_write);
        else passed++;
        exp_q.push_back(id);
        tick();
        e = exp_q.pop_front();
        total++;
        if (got !== e) $display("FAIL r0_capture: got %h expected %h", got, e);
        else passed++;
        total++;
        if (bubble_cnt !== exp_cnt) $display("FAIL r0_cnt: got %h expected %h", bubble_cnt, exp_cnt);
        else passed++;
    endtask

    task automatic test_flush();
        id = lw_i(5'd8, 5'd2);
        exp_q.push_back(id);
        tick();
        e = exp_q.pop_front();
        id = add_i(5'd9, 5'd8, 5'd4);
        flush = 1'b1;
        #1;
        total++;
        if (pc_write !== 1'b0) $display("FAIL flushhaz_pcwrite: got %b expected 0", pc_write);
        else passed++;
        exp_q.push_back(c_bubble);
        bump_cnt();
        tick();
        e = exp_q.pop_front();
        total++;
        if (got !== e) $display("FAIL flushhaz_bubble: got %h expected %h", got, e);
        else passed++;
        total++;
        if (bubble_cnt !== exp_cnt) $display("FAIL flushhaz_cnt: got %h expected %h", bubble_cnt, exp_cnt);
        else passed++;
        id = sw_i(5'd11, 5'd12);
        exp_q.push_back(c_bubble);
        bump_cnt();
        tick();
        flush = 1'b0;
        e = exp_q.pop_front();
        total++;
        if (ex_mw !== 1'b0 || got !== e) $display("FAIL flush_store: got %h expected %h", got, e);
        else passed++;
        total++;
        if (bubble_cnt !== exp_cnt) $display("FAIL flush_cnt: got %h expected %h", bubble_cnt, exp_cnt);
        else passed++;
    endtask

    task automatic test_rst_mid_stall();
        id = lw_i(5'd10, 5'd1);
        tick();
        id = add_i(5'd2, 5'd3, 5'd10);
        #1;
        total++;
        if (pc_write !== 1'b0) $display("FAIL rststall_pre: got %b expected 0", pc_write);
        else passed++;
        rst = 1'b1;
        exp_q.push_back(c_bubble);
        exp_cnt = '0;
        tick();
        rst = 1'b0;
        e = exp_q.pop_front();
        total++;
        if (got !== e) $display("FAIL rststall_regs: got %h expected %h", got, e);
        else passed++;
        total++;
        if (bubble_cnt !== exp_cnt) $display("FAIL rststall_cnt: got %h expected %h", bubble_cnt, exp_cnt);
        else passed++;
        total++;
        if ({pc_write, if_id_write} !== 2'b11)
            $display("FAIL rststall_pcwrite: got %b expected 11", {pc_write, if_id_write});
        else passed++;
    endtask

    task automatic test_saturation();
        id = add_i(5'd4, 5'd5, 5'd6);
        flush = 1'b1;
        for (int i = 0; i < 65534; i++) begin
            tick();
            bump_cnt();
        end
        total++;
        if (bubble_cnt !== 16'hFFFE) $display("FAIL sat_preload: got %h expected fffe", bubble_cnt);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(c_bubble);
            bump_cnt();
            tick();
            e = exp_q.pop_front();
            total++;
            if (got !== e || bubble_cnt !== exp_cnt)
                $display("FAIL sat_step%0d: got %h/%h expected %h/%h", i, got, bubble_cnt, e, exp_cnt);
            else passed++;
        end
        total++;
        if (bubble_cnt !== 16'hFFFF) $display("FAIL sat_hold: got %h expected ffff", bubble_cnt);
        else passed++;
        flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_no_dep();
        test_load_use("ldrs", lw_i(5'd5, 5'd2), add_i(5'd6, 5'd5, 5'd7));
        test_load_use("ldst", lw_i(5'd4, 5'd3), sw_i(5'd4, 5'd9));
        test_back_to_back();
        test_load_r0();
        test_flush();
        test_rst_mid_stall();
        test_saturation();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
